// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and parameter-legality helper for the timebase
package tick_gen_pkg;
  localparam int DIV_MIN = 2;
  localparam int CNT_W_DEF = 27;
  function automatic bit div_ok(input longint v);
    return v >= DIV_MIN;
  endfunction
endpackage

// File: rtl/pulse_div.sv
// pulse_div: free-running modulo-N counter with a registered one-cycle wrap pulse
module pulse_div #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  logic [W-1:0] cnt;
  // count 0..N-1 and flag the wrap edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt == LAST ? '0 : cnt + W'(1);
      tick <= cnt == LAST;
    end
endmodule

// File: rtl/tick_gen.sv
// tick_gen: 1 Hz / 2 Hz / blink / scan timebase with programmable fast period
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int CLOCK_FREQ   = 1000,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FAST_DEFAULT = 125,
  parameter int SCAN_DIV     = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             sync_clr,
  input  logic             fast,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             tick_1hz,
  output logic             tick_2hz,
  output logic             blink,
  output logic             tick_scan,
  output logic             div_err
);
  localparam logic [CNT_W-1:0] CF  = CNT_W'(CLOCK_FREQ);
  localparam logic [CNT_W-1:0] FD  = CNT_W'(FAST_DEFAULT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN = CNT_W'(DIV_MIN);

  if (!div_ok(CLOCK_FREQ) || !div_ok(FAST_DEFAULT) || !div_ok(SCAN_DIV) ||
      longint'(CLOCK_FREQ) >= (longint'(1) << CNT_W) ||
      longint'(FAST_DEFAULT) >= (longint'(1) << CNT_W)) begin : g_bad_params
    $error("tick_gen: illegal parameter set");
  end

  logic [CNT_W-1:0] cnt, fast_reg, per, half;
  logic wrap, mid, val_ok;

  // terminal uses >= so a period shrunk below cnt wraps at once instead of overrunning
  assign per    = fast ? fast_reg : CF;
  assign half   = per >> 1;
  assign wrap   = cnt >= per - ONE;
  assign mid    = cnt == half - ONE;
  assign val_ok = div_val >= MIN;

  // period counter with clear/hold priority, tick decode and blink toggle
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      tick_1hz <= 1'b0;
      tick_2hz <= 1'b0;
      blink    <= 1'b0;
    end else if (sync_clr) begin
      cnt      <= '0;
      tick_1hz <= 1'b0;
      tick_2hz <= 1'b0;
      blink    <= 1'b0;
    end else if (!run) begin
      tick_1hz <= 1'b0;
      tick_2hz <= 1'b0;
    end else begin
      cnt      <= wrap ? '0 : cnt + ONE;
      tick_1hz <= wrap;
      tick_2hz <= wrap | mid;
      blink    <= blink ^ (wrap | mid);
    end

  // fast-period register; too-short loads are rejected with a one-cycle error
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      fast_reg <= FD;
      div_err  <= 1'b0;
    end else begin
      div_err <= div_load && !val_ok;
      if (div_load && val_ok) fast_reg <= div_val;
    end

  pulse_div #(.N(SCAN_DIV), .W($clog2(SCAN_DIV))) u_scan (
    .clk  (sys_clk),
    .rst_n(rst_n),
    .tick (tick_scan)
  );
endmodule
